qproc_time_arb: RTL and testbench
=================================

# qproc_time_arb

Command arbiter and sequencer for the processor's 48-bit absolute time counter controller. It accepts time commands (reset, init-to-offset, signed update, run/stop) from three requesters: core, external trigger logic and host. It grants one command at a time and drives the counter controller's `time_rst/init/updt/en` and `updt_dt` inputs. It holds each command stable for the exact window the counter controller needs to sample it, so requesters never have to know that controller's internal state sequence.

## Interface
- `RR` — default 0 — 0: fixed priority (req 2 host > req 1 ext > req 0 core); 1: round-robin.
- `t_clk_i` — in — 1 — time clock; all logic is on its rising edge.
- `t_rst_i` — in — 1 — reset, synchronous, active-high.
- `req_valid_i` — in — 3 — per-requester command valid; bit i is requester i.
- `req_op_i` — in — 6 — opcode of requester i at `[2i+1:2i]`:
  - 00 RST: time := 0
  - 01 INIT: time := dt, counter runs
  - 10 UPDT: time += signed dt
  - 11 RUN: run := dt[0]
- `req_dt_i` — in — 96 — 32-bit operand of requester i at `[32i+31:32i]`.
- `req_ready_o` — out — 3 — per-requester accept; transfer occurs when valid & ready.
- `time_rst_o` — out — 1 — one-cycle reset pulse to the counter controller.
- `time_init_o` — out — 1 — one-cycle init pulse.
- `time_updt_o` — out — 1 — one-cycle update pulse.
- `time_en_o` — out — 1 — run level, equal to the internal run flag.
- `updt_dt_o` — out — 32 — operand to the counter controller; holds the last accepted dt.
- `busy_o` — out — 1 — high while a command window is open.
- `last_src_o` — out — 2 — index of the last granted requester.
- `cmd_cnt_o` — out — 16 — count of accepted commands; wraps 0xFFFF→0.

## Operation
- **States**
  - ST_IDLE: ready may be asserted.
  - ST_ISSUE: one cycle; the pulse output is high.
  - ST_HOLD: counts down the remaining window.
- **Grant (ST_IDLE only, combinational from `req_valid_i`)**
  - Exactly one `req_ready_o` bit is high: the bit of the selected valid requester. All bits are 0 if no requester is valid or the state is not ST_IDLE.
  - RR=0: the highest-index valid requester wins.
  - RR=1: the search starts at (last_src+1) mod 3 and proceeds upward with wrap. last_src resets to 2, so requester 0 is searched first after reset.
- **On accept (cycle n)**
  - Register op, dt and source.
  - Increment `cmd_cnt_o`.
  - Go to ST_ISSUE.
- **Window length W (cycles, from n+1 inclusive) and action**
  - RST, W=2: `time_rst_o`=1 at n+1; run unchanged.
  - INIT, W=3: `time_init_o`=1 at n+1; run:=1 at n+1, because the counter controller increments after loading the offset.
  - UPDT, W=2: `time_updt_o`=1 at n+1.
  - RUN, W=1: `time_en_o`=dt[0] from n+1; no pulse.
- **Operand timing**
  - `updt_dt_o` takes the accepted dt at n+1 and holds it at least through n+W.
  - The counter controller samples it at n+3 for INIT and at n+2 for UPDT.
  - After the window, `updt_dt_o` keeps its value until the next accept (any op, including RST and RUN).
- **State sequence:** ST_ISSUE (n+1) → ST_HOLD for W-1 cycles → ST_IDLE at n+1+W. For W=1, ST_ISSUE goes directly to ST_IDLE.
- **Status:** `busy_o` = (state ≠ ST_IDLE).
- **Simultaneous valids:** only the granted requester is accepted. Losers keep valid asserted and are not dropped.
- **Valid deasserted before grant:** no effect and no count.

## Timing
- **Reset values (cycle after `t_rst_i` high):**
  - pulses 0; `time_en_o` 0; `updt_dt_o` 0
  - `busy_o` 0; `last_src_o` 2; `cmd_cnt_o` 0
  - state ST_IDLE
- **Ready during reset:** `req_ready_o` is 0 during any cycle in which `t_rst_i` is high.
- **Reset mid-window:** abort. No further pulse is issued, and run is cleared.
- **Latency:** accept at n → output change at n+1 (all outputs registered).
- **Earliest next accept:** n+1+W. Command throughput for back-to-back RST/UPDT is one per 3 cycles; for INIT, one per 4 cycles.
- **Pulse exclusivity:** at most one of `time_rst_o`/`time_init_o`/`time_updt_o` is high in any cycle.
- **UPDT arithmetic:** dt is passed through unmodified. Sign extension to 48 bits is done by the counter controller.

## Test plan
- **Single INIT:** core INIT dt=0x0000_1000 accepted at cycle 10.
  - `time_init_o` high only at cycle 11.
  - `updt_dt_o`=0x1000 over cycles 11–13.
  - `time_en_o`=1 from cycle 11.
  - ready low over cycles 11–13, high again at cycle 14.
- **Fixed-priority contention (RR=0):** all three valid with UPDT dt = 1, 2, 3 (requesters 0, 1, 2).
  - Accept order: host (dt=3), ext (dt=2), core (dt=1), 3 cycles apart.
  - `last_src_o` sequence 2, 1, 0; `cmd_cnt_o` ends at 3.
- **Round-robin (RR=1):** requesters 0 and 2 held valid continuously with RUN.
  - Grants alternate 0, 2, 0, 2, starting with 0 after reset.
- **Negative update:** UPDT dt=0xFFFF_FFFE.
  - `updt_dt_o`=0xFFFF_FFFE at n+1 and n+2.
  - `time_updt_o` pulses once.
- **RUN/RST interplay:**
  - RUN dt=1 → `time_en_o`=1.
  - RST → one `time_rst_o` pulse, `time_en_o` stays 1.
  - RUN dt=0 → `time_en_o`=0.
- **Reset mid-operation:** `t_rst_i` asserted at n+2 of an INIT.
  - All outputs at reset values at n+3; no further pulse.
  - `cmd_cnt_o`=0.
  - Next accept possible at n+4, once `t_rst_i` has dropped.

Source files
------------

// File: rtl/qproc_time_arb_if.sv
// Requester command bus for the time-counter arbiter.
// Three requesters share one valid/ready handshake bundle.
interface qproc_time_arb_if;
  logic [2:0]  req_valid_i;
  logic [5:0]  req_op_i;
  logic [95:0] req_dt_i;
  logic [2:0]  req_ready_o;

  modport master (
    output req_valid_i,
    output req_op_i,
    output req_dt_i,
    input  req_ready_o
  );

  modport slave (
    input  req_valid_i,
    input  req_op_i,
    input  req_dt_i,
    output req_ready_o
  );
endinterface

// File: rtl/qproc_time_arb.sv
// Time-command arbiter/sequencer for the 48-bit time counter.
// Grants one command and holds it for the controller's window.
module qproc_time_arb #(
  parameter bit RR = 1'b0
) (
  input  logic              t_clk_i,
  input  logic              t_rst_i,
  qproc_time_arb_if.slave   req,
  output logic              time_rst_o,
  output logic              time_init_o,
  output logic              time_updt_o,
  output logic              time_en_o,
  output logic [31:0]       updt_dt_o,
  output logic              busy_o,
  output logic [1:0]        last_src_o,
  output logic [15:0]       cmd_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_HOLD
  } st_t;

  localparam logic [1:0] OP_RST  = 2'b00;
  localparam logic [1:0] OP_INIT = 2'b01;
  localparam logic [1:0] OP_UPDT = 2'b10;
  localparam logic [1:0] OP_RUN  = 2'b11;

  st_t         state;
  logic [1:0]  op_q;
  logic        hold_q;
  logic [2:0]  gnt;
  logic [1:0]  sel;
  logic        found;
  logic [1:0]  c0;
  logic [1:0]  c1;
  logic [1:0]  c2;
  logic        acc;
  logic [1:0]  op_in;
  logic [31:0] dt_in;

  function automatic logic [1:0] inc3(
    input logic [1:0] a
  );
    return (a == 2'd2) ? 2'd0 : a + 2'd1;
  endfunction

  assign c0 = inc3(last_src_o);
  assign c1 = inc3(c0);
  assign c2 = inc3(c1);

  always_comb begin
    sel   = 2'd0;
    found = 1'b0;
    if (RR) begin
      if (req.req_valid_i[c0]) begin
        sel   = c0;
        found = 1'b1;
      end else if (req.req_valid_i[c1]) begin
        sel   = c1;
        found = 1'b1;
      end else if (req.req_valid_i[c2]) begin
        sel   = c2;
        found = 1'b1;
      end
    end else begin
      if (req.req_valid_i[2]) begin
        sel   = 2'd2;
        found = 1'b1;
      end else if (req.req_valid_i[1]) begin
        sel   = 2'd1;
        found = 1'b1;
      end else if (req.req_valid_i[0]) begin
        sel   = 2'd0;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    gnt = 3'b000;
    if (found && state == ST_IDLE
        && !t_rst_i) begin
      gnt = 3'b001 << sel;
    end
  end

  assign req.req_ready_o = gnt;
  assign acc   = |gnt;
  assign op_in = req.req_op_i[{sel, 1'b0} +: 2];
  assign dt_in = req.req_dt_i[{sel, 5'b0} +: 32];
  assign busy_o = (state != ST_IDLE);

  always_ff @(posedge t_clk_i) begin
    if (t_rst_i) begin
      state       <= ST_IDLE;
      op_q        <= OP_RST;
      hold_q      <= 1'b0;
      time_rst_o  <= 1'b0;
      time_init_o <= 1'b0;
      time_updt_o <= 1'b0;
      time_en_o   <= 1'b0;
      updt_dt_o   <= '0;
      last_src_o  <= 2'd2;
      cmd_cnt_o   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (acc) begin
            op_q        <= op_in;
            updt_dt_o   <= dt_in;
            last_src_o  <= sel;
            cmd_cnt_o   <= cmd_cnt_o + 16'd1;
            state       <= ST_ISSUE;
            time_rst_o  <= (op_in == OP_RST);
            time_init_o <= (op_in == OP_INIT);
            time_updt_o <= (op_in == OP_UPDT);
            // controller counts right after loading the offset
            if (op_in == OP_INIT)
              time_en_o <= 1'b1;
            if (op_in == OP_RUN)
              time_en_o <= dt_in[0];
          end
        end
        ST_ISSUE: begin
          time_rst_o  <= 1'b0;
          time_init_o <= 1'b0;
          time_updt_o <= 1'b0;
          if (op_q == OP_RUN) begin
            state <= ST_IDLE;
          end else begin
            state  <= ST_HOLD;
            hold_q <= (op_q == OP_INIT);
          end
        end
        ST_HOLD: begin
          if (hold_q)
            hold_q <= 1'b0;
          else
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qproc_time_arb.sv
// Scoreboard bench for qproc_time_arb.
// Fixed-priority and round-robin instances side by side.
module tb_qproc_time_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  qproc_time_arb_if if0();
  qproc_time_arb_if if1();

  logic        d0_rst, d0_init, d0_updt, d0_en;
  logic [31:0] d0_dt;
  logic        d0_busy;
  logic [1:0]  d0_src;
  logic [15:0] d0_cnt;

  logic        d1_rst, d1_init, d1_updt, d1_en;
  logic [31:0] d1_dt;
  logic        d1_busy;
  logic [1:0]  d1_src;
  logic [15:0] d1_cnt;

  qproc_time_arb #(.RR(1'b0)) dut0 (
    .t_clk_i     (clk),
    .t_rst_i     (rst),
    .req         (if0),
    .time_rst_o  (d0_rst),
    .time_init_o (d0_init),
    .time_updt_o (d0_updt),
    .time_en_o   (d0_en),
    .updt_dt_o   (d0_dt),
    .busy_o      (d0_busy),
    .last_src_o  (d0_src),
    .cmd_cnt_o   (d0_cnt)
  );

  qproc_time_arb #(.RR(1'b1)) dut1 (
    .t_clk_i     (clk),
    .t_rst_i     (rst),
    .req         (if1),
    .time_rst_o  (d1_rst),
    .time_init_o (d1_init),
    .time_updt_o (d1_updt),
    .time_en_o   (d1_en),
    .updt_dt_o   (d1_dt),
    .busy_o      (d1_busy),
    .last_src_o  (d1_src),
    .cmd_cnt_o   (d1_cnt)
  );

  typedef struct {
    logic [2:0]  pulse;
    logic [31:0] dt;
    logic [1:0]  src;
    logic [15:0] cnt;
    logic        en;
  } exp_t;

  exp_t       q0[$];
  logic [1:0] q1[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(
    input string       name,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h",
               name, act, exp);
    end
  endtask

  task automatic push0(
    input logic [2:0]  p,
    input logic [31:0] dt,
    input logic [1:0]  src,
    input logic [15:0] cnt,
    input logic        en
  );
    exp_t e;
    e.pulse = p;
    e.dt    = dt;
    e.src   = src;
    e.cnt   = cnt;
    e.en    = en;
    q0.push_back(e);
  endtask

  // command windows open on busy rising
  initial begin : mon0
    logic bp;
    exp_t e;
    bp = 1'b0;
    forever begin
      @(negedge clk);
      if (d0_busy && !bp) begin
        if (q0.size() == 0) begin
          total++;
          bad++;
          $display("FAIL mon0_unexpected src=%0d",
                   d0_src);
        end else begin
          e = q0.pop_front();
          chk("mon0_pulse",
              {d0_rst, d0_init, d0_updt}, e.pulse);
          chk("mon0_dt", d0_dt, e.dt);
          chk("mon0_src", d0_src, e.src);
          chk("mon0_cnt", d0_cnt, e.cnt);
          chk("mon0_en", d0_en, e.en);
        end
      end
      bp = d0_busy;
    end
  end

  initial begin : mon1
    logic [2:0] hits;
    logic [1:0] s;
    forever begin
      @(negedge clk);
      hits = if1.req_valid_i & if1.req_ready_o;
      if (|hits) begin
        if (q1.size() == 0) begin
          total++;
          bad++;
          $display("FAIL mon1_unexpected hits=%0b",
                   hits);
        end else begin
          s = q1.pop_front();
          chk("mon1_grant", hits, 3'b001 << s);
        end
      end
    end
  end

  task automatic send0(
    input int          r,
    input logic [1:0]  op,
    input logic [31:0] dt
  );
    int k;
    @(posedge clk);
    #1;
    if0.req_op_i[2*r +: 2]  = op;
    if0.req_dt_i[32*r +: 32] = dt;
    if0.req_valid_i[r]       = 1'b1;
    k = 0;
    @(negedge clk);
    while (!if0.req_ready_o[r] && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!if0.req_ready_o[r]) begin
      total++;
      bad++;
      $display("FAIL send0_timeout r=%0d", r);
    end
    @(posedge clk);
    #1;
    if0.req_valid_i[r] = 1'b0;
  endtask

  initial begin : stim
    int k;
    int gc[$];
    logic [2:0] hits;

    if0.req_valid_i = 3'b111;
    if0.req_op_i    = '0;
    if0.req_dt_i    = '0;
    if1.req_valid_i = 3'b111;
    if1.req_op_i    = '0;
    if1.req_dt_i    = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready0", if0.req_ready_o, 3'b000);
    chk("rst_ready1", if1.req_ready_o, 3'b000);
    chk("rst_pulses",
        {d0_rst, d0_init, d0_updt}, 3'b000);
    chk("rst_en", d0_en, 1'b0);
    chk("rst_dt", d0_dt, 32'h0);
    chk("rst_busy", d0_busy, 1'b0);
    chk("rst_src", d0_src, 2'd2);
    chk("rst_cnt", d0_cnt, 16'd0);
    chk("rst_src1", d1_src, 2'd2);
    @(posedge clk);
    #1;
    if0.req_valid_i = 3'b000;
    if1.req_valid_i = 3'b000;
    rst = 1'b0;

    // round robin: 0 and 2 held with RUN
    q1.push_back(2'd0);
    q1.push_back(2'd2);
    q1.push_back(2'd0);
    q1.push_back(2'd2);
    @(posedge clk);
    #1;
    if1.req_op_i    = 6'b11_00_11;
    if1.req_dt_i    = {32'h0, 32'h0, 32'h1};
    if1.req_valid_i = 3'b101;
    k = 0;
    while (q1.size() > 0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("rr_drained", q1.size(), 0);
    @(posedge clk);
    #1;
    if1.req_valid_i = 3'b000;
    repeat (3) @(negedge clk);
    chk("rr_cnt", d1_cnt, 16'd4);
    chk("rr_src", d1_src, 2'd2);
    chk("rr_en", d1_en, 1'b0);

    // single INIT with detailed window
    push0(3'b010, 32'h1000, 2'd0, 16'd1, 1'b1);
    push0(3'b000, 32'h1, 2'd0, 16'd2, 1'b1);
    @(posedge clk);
    #1;
    if0.req_op_i[1:0]  = 2'b01;
    if0.req_dt_i[31:0] = 32'h1000;
    if0.req_valid_i[0] = 1'b1;
    k = 0;
    @(negedge clk);
    while (!if0.req_ready_o[0] && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("init_accept", if0.req_ready_o, 3'b001);
    @(posedge clk);
    #1;
    if0.req_op_i[1:0]  = 2'b11;
    if0.req_dt_i[31:0] = 32'h1;
    @(negedge clk);
    chk("init_p1", d0_init, 1'b1);
    chk("init_dt1", d0_dt, 32'h1000);
    chk("init_en1", d0_en, 1'b1);
    chk("init_rdy1", if0.req_ready_o, 3'b000);
    @(negedge clk);
    chk("init_p2", d0_init, 1'b0);
    chk("init_dt2", d0_dt, 32'h1000);
    chk("init_rdy2", if0.req_ready_o, 3'b000);
    @(negedge clk);
    chk("init_p3", d0_init, 1'b0);
    chk("init_dt3", d0_dt, 32'h1000);
    chk("init_rdy3", if0.req_ready_o, 3'b000);
    @(negedge clk);
    chk("init_rdy4", if0.req_ready_o, 3'b001);
    @(posedge clk);
    #1;
    if0.req_valid_i[0] = 1'b0;

    // fixed priority contention
    push0(3'b001, 32'h3, 2'd2, 16'd3, 1'b1);
    push0(3'b001, 32'h2, 2'd1, 16'd4, 1'b1);
    push0(3'b001, 32'h1, 2'd0, 16'd5, 1'b1);
    @(posedge clk);
    #1;
    if0.req_op_i    = 6'b10_10_10;
    if0.req_dt_i    = {32'h3, 32'h2, 32'h1};
    if0.req_valid_i = 3'b111;
    k = 0;
    while (if0.req_valid_i != 3'b000 && k < 40) begin
      @(negedge clk);
      hits = if0.req_valid_i & if0.req_ready_o;
      if (|hits) gc.push_back(cyc);
      @(posedge clk);
      #1;
      if0.req_valid_i = if0.req_valid_i & ~hits;
      k++;
    end
    chk("prio_ngrants", gc.size(), 3);
    if (gc.size() == 3) begin
      chk("prio_gap1", gc[1] - gc[0], 3);
      chk("prio_gap2", gc[2] - gc[1], 3);
    end

    // negative update
    push0(3'b001, 32'hFFFF_FFFE, 2'd0, 16'd6, 1'b1);
    send0(0, 2'b10, 32'hFFFF_FFFE);
    @(negedge clk);
    @(negedge clk);
    chk("neg_dt2", d0_dt, 32'hFFFF_FFFE);
    chk("neg_once2", d0_updt, 1'b0);
    @(negedge clk);
    chk("neg_once3", d0_updt, 1'b0);

    // RUN / RST interplay
    push0(3'b000, 32'h0, 2'd1, 16'd7, 1'b0);
    send0(1, 2'b11, 32'h0);
    push0(3'b000, 32'h1, 2'd0, 16'd8, 1'b1);
    send0(0, 2'b11, 32'h1);
    push0(3'b100, 32'h55, 2'd2, 16'd9, 1'b1);
    send0(2, 2'b00, 32'h55);
    @(negedge clk);
    @(negedge clk);
    chk("rst_cmd_en", d0_en, 1'b1);
    chk("rst_cmd_once", d0_rst, 1'b0);
    push0(3'b000, 32'h0, 2'd0, 16'd10, 1'b0);
    send0(0, 2'b11, 32'h0);

    // reset in the middle of an INIT window
    push0(3'b010, 32'hABCD, 2'd0, 16'd11, 1'b1);
    push0(3'b000, 32'h1, 2'd1, 16'd1, 1'b1);
    send0(0, 2'b01, 32'hABCD);
    @(posedge clk);
    #1;
    rst = 1'b1;
    if0.req_op_i[3:2]   = 2'b11;
    if0.req_dt_i[63:32] = 32'h1;
    if0.req_valid_i[1]  = 1'b1;
    @(negedge clk);
    chk("mid_rdy2", if0.req_ready_o, 3'b000);
    chk("mid_p2", d0_init, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("mid_rdy3", if0.req_ready_o, 3'b000);
    chk("mid_pul3",
        {d0_rst, d0_init, d0_updt}, 3'b000);
    chk("mid_en3", d0_en, 1'b0);
    chk("mid_dt3", d0_dt, 32'h0);
    chk("mid_busy3", d0_busy, 1'b0);
    chk("mid_src3", d0_src, 2'd2);
    chk("mid_cnt3", d0_cnt, 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rdy4", if0.req_ready_o, 3'b010);
    chk("mid_p4", d0_init, 1'b0);
    @(posedge clk);
    #1;
    if0.req_valid_i[1] = 1'b0;
    repeat (3) @(negedge clk);
    chk("q0_drained", q0.size(), 0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
